// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the register-file write port between N_REQ write-back sources.
// Optional in-flight destination scoreboard enabled by defining WB_SCOREBOARD_EN.
module regfile_wb_arbiter #(
   parameter int unsigned N_REQ = 3,
   parameter int unsigned XLEN  = 64,
   parameter int unsigned AW    = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [N_REQ*AW-1:0]   req_addr,
   input  logic [N_REQ*XLEN-1:0] req_data,
   output logic                  rf_we,
   output logic [AW-1:0]         rf_wa,
   output logic [XLEN-1:0]       rf_wd
`ifdef WB_SCOREBOARD_EN
   ,
   input  logic                  alloc_valid,
   input  logic [AW-1:0]         alloc_addr,
   output logic [31:0]           busy
`endif
);

   localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
   logic             rf_we_q, rf_we_d;
   logic [AW-1:0]    rf_wa_q, rf_wa_d;
   logic [XLEN-1:0]  rf_wd_q, rf_wd_d;

   logic             found;
   logic [PW-1:0]    gnt_idx;
   int unsigned      scan_idx;
   logic             xfer;
   logic [N_REQ-1:0] ready_c;
   logic [AW-1:0]    sel_addr;
   logic [XLEN-1:0]  sel_data;

   // Scan requesters starting at the round-robin pointer; first valid one wins.
   always_comb begin
      found    = 1'b0;
      gnt_idx  = '0;
      scan_idx = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         scan_idx = 32'(rr_ptr_q) + k;
         if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
         if (!found && req_valid[PW'(scan_idx)]) begin
            found   = 1'b1;
            gnt_idx = PW'(scan_idx);
         end
      end
   end

   // Grant is withheld during stall and reset, so a transfer is simply a qualified grant.
   assign xfer = found && !stall && !rst;

   always_comb begin
      ready_c  = '0;
      sel_addr = '0;
      sel_data = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         ready_c[k] = xfer && (PW'(k) == gnt_idx);
         if (PW'(k) == gnt_idx) begin
            sel_addr = req_addr[k*AW +: AW];
            sel_data = req_data[k*XLEN +: XLEN];
         end
      end
   end

   assign req_ready = ready_c;

   // Next-state for pointer and output stage; x0 writes are consumed but never enable the port.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      rf_we_d  = 1'b0;
      rf_wa_d  = rf_wa_q;
      rf_wd_d  = rf_wd_q;
      if (xfer) begin
         rr_ptr_d = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);
         rf_we_d  = (sel_addr != '0);
         rf_wa_d  = sel_addr;
         rf_wd_d  = sel_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= '0;
         rf_we_q  <= 1'b0;
         rf_wa_q  <= '0;
         rf_wd_q  <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         rf_we_q  <= rf_we_d;
         rf_wa_q  <= rf_wa_d;
         rf_wd_q  <= rf_wd_d;
      end
   end

   assign rf_we = rf_we_q;
   assign rf_wa = rf_wa_q;
   assign rf_wd = rf_wd_q;

`ifdef WB_SCOREBOARD_EN
   logic [31:0] busy_q, busy_d;

   // Clear on landing write first so a same-cycle allocation of that register wins.
   always_comb begin
      busy_d = busy_q;
      if (rf_we_q) busy_d[rf_wa_q] = 1'b0;
      if (alloc_valid && (alloc_addr != '0)) busy_d[alloc_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   assign busy = busy_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; scoreboard scenario runs when WB_SCOREBOARD_EN is defined.
module tb_regfile_wb_arbiter;

   localparam int unsigned N_REQ = 3;
   localparam int unsigned XLEN  = 64;
   localparam int unsigned AW    = 5;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  stall;
   logic [N_REQ-1:0]      req_valid;
   logic [N_REQ-1:0]      req_ready;
   logic [N_REQ*AW-1:0]   req_addr;
   logic [N_REQ*XLEN-1:0] req_data;
   logic                  rf_we;
   logic [AW-1:0]         rf_wa;
   logic [XLEN-1:0]       rf_wd;
`ifdef WB_SCOREBOARD_EN
   logic                  alloc_valid;
   logic [AW-1:0]         alloc_addr;
   logic [31:0]           busy;
`endif

   int n_vec = 0;
   int n_err = 0;

   regfile_wb_arbiter #(.N_REQ(N_REQ), .XLEN(XLEN), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .rf_we     (rf_we),
      .rf_wa     (rf_wa),
      .rf_wd     (rf_wd)
`ifdef WB_SCOREBOARD_EN
      ,
      .alloc_valid (alloc_valid),
      .alloc_addr  (alloc_addr),
      .busy        (busy)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req_valid = 3'b111;
      #1;
      n_vec++;
      if (req_ready !== 3'b000) begin
         n_err++; $display("FAIL reset_ready got=%b want=000", req_ready);
      end
      tick();
      tick();
      n_vec++;
      if (rf_we !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 64'd0) begin
         n_err++; $display("FAIL reset_outputs got we=%b wa=%0d wd=%h want 0/0/0", rf_we, rf_wa, rf_wd);
      end
`ifdef WB_SCOREBOARD_EN
      n_vec++;
      if (busy !== 32'd0) begin
         n_err++; $display("FAIL reset_busy got=%h want=0", busy);
      end
`endif
      req_valid = 3'b000;
      rst       = 1'b0;
      #1;
   endtask

   task automatic test_single();
      req_addr[0*AW +: AW]     = 5'd5;
      req_data[0*XLEN +: XLEN] = 64'hDEAD_BEEF;
      req_valid = 3'b001;
      #1;
      n_vec++;
      if (req_ready !== 3'b001) begin
         n_err++; $display("FAIL single_ready got=%b want=001", req_ready);
      end
      tick();
      req_valid = 3'b000;
      n_vec++;
      if (rf_we !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 64'hDEAD_BEEF) begin
         n_err++; $display("FAIL single_write got we=%b wa=%0d wd=%h want 1/5/deadbeef", rf_we, rf_wa, rf_wd);
      end
      tick();
      n_vec++;
      if (rf_we !== 1'b0 || rf_wa !== 5'd5) begin
         n_err++; $display("FAIL single_idle got we=%b wa=%0d want 0/5", rf_we, rf_wa);
      end
   endtask

   task automatic test_round_robin();
      logic [N_REQ-1:0] exp_rdy;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_addr[i*AW +: AW]     = AW'(i + 1);
         req_data[i*XLEN +: XLEN] = 64'h100 + 64'(i);
      end
      req_valid = 3'b111;
      for (int c = 0; c < 6; c++) begin
         #1;
         exp_rdy = 3'b001 << (c % 3);
         n_vec++;
         if (req_ready !== exp_rdy) begin
            n_err++; $display("FAIL rr_ready[%0d] got=%b want=%b", c, req_ready, exp_rdy);
         end
         tick();
         n_vec++;
         if (rf_we !== 1'b1 || rf_wa !== AW'((c % 3) + 1) || rf_wd !== 64'h100 + 64'(c % 3)) begin
            n_err++; $display("FAIL rr_write[%0d] got we=%b wa=%0d wd=%h want 1/%0d/%h",
                              c, rf_we, rf_wa, rf_wd, (c % 3) + 1, 64'h100 + 64'(c % 3));
         end
      end
      req_valid = 3'b000;
      #1;
   endtask

   task automatic test_x0_stall();
      // Pointer is 0 here; x0 write from source 1 moves it to 2.
      req_addr[1*AW +: AW]     = 5'd0;
      req_data[1*XLEN +: XLEN] = 64'hBAD0;
      req_valid = 3'b010;
      #1;
      n_vec++;
      if (req_ready !== 3'b010) begin
         n_err++; $display("FAIL x0_ready got=%b want=010", req_ready);
      end
      tick();
      n_vec++;
      if (rf_we !== 1'b0 || rf_wa !== 5'd0) begin
         n_err++; $display("FAIL x0_write got we=%b wa=%0d want 0/0", rf_we, rf_wa);
      end
      req_valid = 3'b101;
      stall     = 1'b1;
      #1;
      n_vec++;
      if (req_ready !== 3'b000) begin
         n_err++; $display("FAIL stall_ready got=%b want=000", req_ready);
      end
      tick();
      tick();
      n_vec++;
      if (rf_we !== 1'b0 || req_ready !== 3'b000) begin
         n_err++; $display("FAIL stall_hold got we=%b ready=%b want 0/000", rf_we, req_ready);
      end
      stall = 1'b0;
      #1;
      n_vec++;
      if (req_ready !== 3'b100) begin
         n_err++; $display("FAIL unstall_ready got=%b want=100", req_ready);
      end
      tick();
      req_valid = 3'b001;
      n_vec++;
      if (rf_we !== 1'b1 || rf_wa !== 5'd3) begin
         n_err++; $display("FAIL unstall_write got we=%b wa=%0d want 1/3", rf_we, rf_wa);
      end
      #1;
      n_vec++;
      if (req_ready !== 3'b001) begin
         n_err++; $display("FAIL after_stall_ready got=%b want=001", req_ready);
      end
      tick();
      req_valid = 3'b000;
      n_vec++;
      if (rf_we !== 1'b1 || rf_wa !== 5'd1) begin
         n_err++; $display("FAIL after_stall_write got we=%b wa=%0d want 1/1", rf_we, rf_wa);
      end
      #1;
   endtask

   task automatic test_reset_mid();
      // Pointer is 1 here; only source 0 valid so it is still granted.
      req_addr[0*AW +: AW]     = 5'd7;
      req_data[0*XLEN +: XLEN] = 64'h7777;
      req_valid = 3'b001;
      #1;
      tick();
      req_valid = 3'b000;
      n_vec++;
      if (rf_we !== 1'b1 || rf_wa !== 5'd7) begin
         n_err++; $display("FAIL mid_write got we=%b wa=%0d want 1/7", rf_we, rf_wa);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_vec++;
      if (rf_we !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 64'd0) begin
         n_err++; $display("FAIL mid_reset got we=%b wa=%0d wd=%h want 0/0/0", rf_we, rf_wa, rf_wd);
      end
      req_valid = 3'b111;
      #1;
      n_vec++;
      if (req_ready !== 3'b001) begin
         n_err++; $display("FAIL mid_ptr got=%b want=001", req_ready);
      end
      req_valid = 3'b000;
      #1;
   endtask

`ifdef WB_SCOREBOARD_EN
   task automatic test_scoreboard();
      alloc_valid = 1'b1;
      alloc_addr  = 5'd9;
      tick();
      alloc_valid = 1'b0;
      n_vec++;
      if (busy[9] !== 1'b1) begin
         n_err++; $display("FAIL sb_alloc got=%b want=1", busy[9]);
      end
      req_addr[0*AW +: AW]     = 5'd9;
      req_data[0*XLEN +: XLEN] = 64'h99;
      req_valid = 3'b001;
      tick();
      req_valid   = 3'b000;
      alloc_valid = 1'b1;
      alloc_addr  = 5'd9;
      tick();
      alloc_valid = 1'b0;
      n_vec++;
      if (busy[9] !== 1'b1) begin
         n_err++; $display("FAIL sb_set_wins got=%b want=1", busy[9]);
      end
      req_valid = 3'b001;
      tick();
      req_valid = 3'b000;
      n_vec++;
      if (busy[9] !== 1'b1) begin
         n_err++; $display("FAIL sb_pending got=%b want=1", busy[9]);
      end
      tick();
      n_vec++;
      if (busy[9] !== 1'b0) begin
         n_err++; $display("FAIL sb_clear got=%b want=0", busy[9]);
      end
      alloc_valid = 1'b1;
      alloc_addr  = 5'd0;
      tick();
      alloc_valid = 1'b0;
      n_vec++;
      if (busy !== 32'd0) begin
         n_err++; $display("FAIL sb_x0 got=%h want=0", busy);
      end
   endtask
`endif

   initial begin
      rst       = 1'b1;
      stall     = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
`ifdef WB_SCOREBOARD_EN
      alloc_valid = 1'b0;
      alloc_addr  = '0;
`endif
      test_reset();
      test_single();
      test_round_robin();
      test_x0_stall();
      test_reset_mid();
`ifdef WB_SCOREBOARD_EN
      test_scoreboard();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
